// File: rtl/seq_pkg.sv
// Shared opcodes, state/ALU encodings and bus-source indices for the Mini-SRC
// control-step sequencer.
package seq_pkg;

  localparam int BUS_SRCS = 24;
  localparam int NREGS    = 16;

  localparam logic [4:0] ADD  = 5'd3;
  localparam logic [4:0] SUB  = 5'd4;
  localparam logic [4:0] AND  = 5'd5;
  localparam logic [4:0] OR   = 5'd6;
  localparam logic [4:0] ADDI = 5'd12;
  localparam logic [4:0] ANDI = 5'd13;
  localparam logic [4:0] ORI  = 5'd14;
  localparam logic [4:0] MUL  = 5'd15;
  localparam logic [4:0] DIV  = 5'd16;
  localparam logic [4:0] NOP  = 5'd26;
  localparam logic [4:0] HALT = 5'd27;

  // One-hot bus source positions above the general registers (R0..R15 = 0..15)
  localparam int BUS_HI     = 16;
  localparam int BUS_LO     = 17;
  localparam int BUS_ZHIGH  = 18;
  localparam int BUS_ZLOW   = 19;
  localparam int BUS_PC     = 20;
  localparam int BUS_MDR    = 21;
  localparam int BUS_INPORT = 22;
  localparam int BUS_C      = 23;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    ALU_NONE = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_MUL  = 4'd5,
    ALU_DIV  = 4'd6
  } alu_op_t;

  function automatic logic is_alu_op(input logic [4:0] op);
    case (op)
      ADD, SUB, AND, OR, ADDI, ANDI, ORI, MUL, DIV: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_imm_op(input logic [4:0] op);
    case (op)
      ADDI, ANDI, ORI: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic is_muldiv_op(input logic [4:0] op);
    case (op)
      MUL, DIV: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t alu_of(input logic [4:0] op);
    case (op)
      ADD, ADDI: return ALU_ADD;
      SUB:       return ALU_SUB;
      AND, ANDI: return ALU_AND;
      OR, ORI:   return ALU_OR;
      MUL:       return ALU_MUL;
      DIV:       return ALU_DIV;
      default:   return ALU_NONE;
    endcase
  endfunction

  function automatic logic [BUS_SRCS-1:0] bus_bit(input int idx);
    return 24'd1 << idx;
  endfunction

endpackage

// File: rtl/reg_field_decode.sv
// 4-bit register field to 16-bit one-hot select.
module reg_field_decode
  import seq_pkg::*;
(
  input  logic [3:0]       field,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = 16'd1 << field;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0..T6 control-step sequencer for the single-bus Mini-SRC datapath.
// Define SEQ_PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counters.
module control_sequencer
  import seq_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                run,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic [BUS_SRCS-1:0] bus_out_sel,
  output logic [NREGS-1:0]    reg_in,
  output logic                pc_in,
  output logic                ir_in,
  output logic                mar_in,
  output logic                mdr_in,
  output logic                y_in,
  output logic                z_in,
  output logic                hi_in,
  output logic                lo_in,
  output logic                inc_pc,
  output logic                mem_read,
  output logic [3:0]          alu_op,
  output logic                busy,
  output logic                halted,
  output logic                illegal_op
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instr_cnt
`endif
);

  state_t            state_q, state_d;
  logic              illegal_q, illegal_d;
  logic [4:0]        op_s;
  logic [3:0]        ra_s, rb_s, rc_s;
  logic [NREGS-1:0]  ra_oh_s, rb_oh_s, rc_oh_s;
  logic              unused_imm_s;

  assign op_s         = ir[31:27];
  assign ra_s         = ir[26:23];
  assign rb_s         = ir[22:19];
  assign rc_s         = ir[18:15];
  assign unused_imm_s = ^ir[14:0];

  reg_field_decode u_dec_ra (.field(ra_s), .onehot(ra_oh_s));
  reg_field_decode u_dec_rb (.field(rb_s), .onehot(rb_oh_s));
  reg_field_decode u_dec_rc (.field(rc_s), .onehot(rc_oh_s));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: state_d = run ? S_T0 : S_IDLE;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_alu_op(op_s)) begin
          state_d = S_T4;
        end else if (op_s == NOP) begin
          state_d = S_IDLE;
        end else if (op_s == HALT) begin
          state_d = S_HALT;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_muldiv_op(op_s) ? S_T6 : S_IDLE;
      S_T6:   state_d = S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Exactly one bus driver per step; IDLE and HALT leave the bus idling at 0.
  always_comb begin
    bus_out_sel = 24'h000000;
    reg_in      = 16'h0000;
    pc_in       = 1'b0;
    ir_in       = 1'b0;
    mar_in      = 1'b0;
    mdr_in      = 1'b0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    hi_in       = 1'b0;
    lo_in       = 1'b0;
    inc_pc      = 1'b0;
    mem_read    = 1'b0;
    alu_op      = ALU_NONE;
    busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    halted      = (state_q == S_HALT);
    illegal_op  = illegal_q;
    case (state_q)
      S_T0: begin
        bus_out_sel = bus_bit(BUS_PC);
        mar_in      = 1'b1;
        inc_pc      = 1'b1;
        z_in        = 1'b1;
      end
      S_T1: begin
        bus_out_sel = bus_bit(BUS_ZLOW);
        pc_in       = 1'b1;
        mem_read    = 1'b1;
        mdr_in      = mem_ready;
      end
      S_T2: begin
        bus_out_sel = bus_bit(BUS_MDR);
        ir_in       = 1'b1;
      end
      S_T3: begin
        if (is_alu_op(op_s)) begin
          bus_out_sel = {8'h00, rb_oh_s};
          y_in        = 1'b1;
        end else begin
          bus_out_sel = 24'h000000;
        end
      end
      S_T4: begin
        z_in   = 1'b1;
        alu_op = alu_of(op_s);
        if (is_imm_op(op_s)) begin
          bus_out_sel = bus_bit(BUS_C);
        end else begin
          bus_out_sel = {8'h00, rc_oh_s};
        end
      end
      S_T5: begin
        bus_out_sel = bus_bit(BUS_ZLOW);
        if (is_muldiv_op(op_s)) begin
          lo_in = 1'b1;
        end else begin
          reg_in = ra_oh_s;
        end
      end
      S_T6: begin
        bus_out_sel = bus_bit(BUS_ZHIGH);
        hi_in       = 1'b1;
      end
      default: begin
        bus_out_sel = 24'h000000;
      end
    endcase
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        retire_s;

  // A legal instruction retires on its return to IDLE, or on entry to HALT.
  always_comb begin
    retire_s = ((state_q == S_T3) && ((op_s == NOP) || (op_s == HALT))) ||
               ((state_q == S_T5) && !is_muldiv_op(op_s)) ||
               (state_q == S_T6);
    cycle_cnt_d = busy     ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
    instr_cnt_d = retire_s ? instr_cnt_q + 32'd1 : instr_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed literal checks plus randomized instruction
// stream compared every cycle against a step-list model of the sequencer.
module tb_control_sequencer;
  import seq_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] ir = 32'd0;

  logic [23:0] bus_out_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
  logic        inc_pc, mem_read, busy, halted, illegal_op;
  logic [3:0]  alu_op;
  logic [9:0]  dut_ctl;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .mem_ready(mem_ready),
    .bus_out_sel(bus_out_sel), .reg_in(reg_in), .pc_in(pc_in), .ir_in(ir_in),
    .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in), .hi_in(hi_in),
    .lo_in(lo_in), .inc_pc(inc_pc), .mem_read(mem_read), .alu_op(alu_op),
    .busy(busy), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  assign dut_ctl = {pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, inc_pc, mem_read};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: an instruction is a list of steps ----
  localparam int K_PC = 9, K_IR = 8, K_MAR = 7, K_MDR = 6, K_Y = 5;
  localparam int K_Z = 4, K_HI = 3, K_LO = 2, K_INC = 1, K_MRD = 0;

  typedef struct packed {
    logic [23:0] bus;
    logic [15:0] rin;
    logic [9:0]  ctl;
    logic [3:0]  alu;
    logic        wait_mem;
    logic        set_ill;
    logic        to_halt;
  } step_t;

  step_t plan[$];
  bit    m_halt = 1'b0;
  bit    m_ill  = 1'b0;
  bit    m_live = 1'b0;

  function automatic logic [9:0] cb(input int k);
    return 10'd1 << k;
  endfunction

  function automatic logic [23:0] src(input int k);
    return 24'd1 << k;
  endfunction

  function automatic step_t mk(input logic [23:0] bus, input logic [9:0] ctl);
    step_t s;
    s = '0;
    s.bus = bus;
    s.ctl = ctl;
    return s;
  endfunction

  function automatic void build(input logic [31:0] i);
    logic [4:0] op;
    logic [3:0] alu;
    int         ra, rb, rc;
    step_t      s;
    op = i[31:27];
    ra = int'(i[26:23]);
    rb = int'(i[22:19]);
    rc = int'(i[18:15]);
    case (op)
      5'd3, 5'd12:  alu = 4'd1;
      5'd4:         alu = 4'd2;
      5'd5, 5'd13:  alu = 4'd3;
      5'd6, 5'd14:  alu = 4'd4;
      5'd15:        alu = 4'd5;
      5'd16:        alu = 4'd6;
      default:      alu = 4'd0;
    endcase
    plan.push_back(mk(src(20), cb(K_MAR) | cb(K_INC) | cb(K_Z)));
    s = mk(src(19), cb(K_PC) | cb(K_MRD));
    s.wait_mem = 1'b1;
    plan.push_back(s);
    plan.push_back(mk(src(21), cb(K_IR)));
    if (alu != 4'd0) begin
      plan.push_back(mk(src(rb), cb(K_Y)));
      s = mk((op >= 5'd12 && op <= 5'd14) ? src(23) : src(rc), cb(K_Z));
      s.alu = alu;
      plan.push_back(s);
      if (op == 5'd15 || op == 5'd16) begin
        plan.push_back(mk(src(19), cb(K_LO)));
        plan.push_back(mk(src(18), cb(K_HI)));
      end else begin
        s = mk(src(19), 10'd0);
        s.rin = 16'd1 << ra;
        plan.push_back(s);
      end
    end else begin
      s = mk(24'd0, 10'd0);
      s.to_halt = (op == 5'd27);
      s.set_ill = (op != 5'd26) && (op != 5'd27);
      plan.push_back(s);
    end
  endfunction

  // Model advance on each rising edge, then every-cycle comparison 1 ns later.
  initial begin
    step_t       s;
    logic [23:0] eb;
    logic [15:0] er;
    logic [9:0]  ec;
    logic [3:0]  ea;
    logic [2:0]  est;
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        plan.delete();
        m_halt = 1'b0;
        m_ill  = 1'b0;
        m_live = 1'b1;
      end else if (m_live) begin
        if (plan.size() == 0) begin
          if (!m_halt && run) build(ir);
        end else begin
          s = plan[0];
          if (!(s.wait_mem && !mem_ready)) begin
            if (s.set_ill) m_ill = 1'b1;
            if (s.to_halt) m_halt = 1'b1;
            void'(plan.pop_front());
          end
        end
      end
      #1;
      if (m_live) begin
        if (plan.size() > 0) begin
          s  = plan[0];
          eb = s.bus;
          er = s.rin;
          ec = s.ctl;
          if (s.wait_mem && mem_ready) ec[K_MDR] = 1'b1;
          ea = s.alu;
          est = {1'b1, 1'b0, m_ill};
        end else begin
          eb = 24'd0;
          er = 16'd0;
          ec = 10'd0;
          ea = 4'd0;
          est = {1'b0, m_halt, m_ill};
        end
        chk("model_bus", 32'(bus_out_sel), 32'(eb));
        chk("model_reg_in", 32'(reg_in), 32'(er));
        chk("model_ctl", 32'(dut_ctl), 32'(ec));
        chk("model_alu", 32'(alu_op), 32'(ea));
        chk("model_status", 32'({busy, halted, illegal_op}), 32'(est));
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60; k++) begin
      if (plan.size() == 0) break;
      cyc();
    end
    if (plan.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: instruction still running after 60 cycles");
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  initial begin
    logic [4:0]  legal_ops [9];
    logic [4:0]  op;
    logic [31:0] rnd;
    int          r;
    legal_ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16};

    repeat (3) cyc();
    chk("rst_bus", 32'(bus_out_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    reset_n = 1'b1;
    cyc();

    // add R3,R1,R2 with memory always ready
    ir = enc(5'd3, 4'd3, 4'd1, 4'd2);
    run = 1'b1;
    cyc();
    run = 1'b0;
    chk("add_t0_bus", 32'(bus_out_sel), 32'h0010_0000);
    cyc();
    chk("add_t1_memread", 32'(mem_read), 32'd1);
    cyc();
    cyc();
    chk("add_t3_bus", 32'(bus_out_sel), 32'h0000_0002);
    cyc();
    chk("add_t4_bus", 32'(bus_out_sel), 32'h0000_0004);
    chk("add_t4_alu", 32'(alu_op), 32'd1);
    cyc();
    chk("add_t5_reg_in", 32'(reg_in), 32'h0000_0008);
    chk("add_t5_bus", 32'(bus_out_sel), 32'h0008_0000);
    cyc();
    chk("add_idle_busy", 32'(busy), 32'd0);

    // reset in T4 aborts the instruction
    run = 1'b1;
    cyc();
    run = 1'b0;
    repeat (4) cyc();
    reset_n = 1'b0;
    cyc();
    chk("abort_bus", 32'(bus_out_sel), 32'd0);
    chk("abort_ctl", 32'(dut_ctl), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    run = 1'b1;
    cyc();
    run = 1'b0;
    chk("restart_bus", 32'(bus_out_sel), 32'h0010_0000);
    wait_idle();

    // three memory wait states in T1
    run = 1'b1;
    cyc();
    run = 1'b0;
    mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      chk("wait_memread", 32'(mem_read), 32'd1);
      chk("wait_mdr_in", 32'(mdr_in), (k == 3) ? 32'd1 : 32'd0);
    end
    cyc();
    chk("wait_ir_in", 32'(ir_in), 32'd1);
    chk("wait_t2_memread", 32'(mem_read), 32'd0);
    wait_idle();

    // mul R4,R5: LO then HI, no register write
    ir = enc(5'd15, 4'd0, 4'd4, 4'd5);
    run = 1'b1;
    cyc();
    run = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) cyc();
      chk("mul_reg_in", 32'(reg_in), 32'd0);
      if (k == 5) begin
        chk("mul_t5_bus", 32'(bus_out_sel), 32'h0008_0000);
        chk("mul_t5_lo_in", 32'(lo_in), 32'd1);
      end
      if (k == 6) begin
        chk("mul_t6_bus", 32'(bus_out_sel), 32'h0004_0000);
        chk("mul_t6_hi_in", 32'(hi_in), 32'd1);
      end
    end
    cyc();
    chk("mul_idle_busy", 32'(busy), 32'd0);

    // ori R2,R2,5
    ir = {5'd14, 4'd2, 4'd2, 4'd0, 15'd5};
    run = 1'b1;
    cyc();
    run = 1'b0;
    repeat (4) cyc();
    chk("ori_t4_bus", 32'(bus_out_sel), 32'h0080_0000);
    chk("ori_t4_alu", 32'(alu_op), 32'd4);
    cyc();
    chk("ori_t5_reg_in", 32'(reg_in), 32'h0000_0004);
    wait_idle();

    // undefined opcode is sticky
    ir = {5'd31, 27'd0};
    run = 1'b1;
    cyc();
    run = 1'b0;
    wait_idle();
    chk("illegal_set", 32'(illegal_op), 32'd1);
    ir = enc(5'd4, 4'd1, 4'd2, 4'd3);
    run = 1'b1;
    cyc();
    run = 1'b0;
    wait_idle();
    chk("illegal_sticky", 32'(illegal_op), 32'd1);

    // halt absorbs run; only reset exits
    ir = {5'd27, 27'd0};
    run = 1'b1;
    cyc();
    wait_idle();
    repeat (10) cyc();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    reset_n = 1'b0;
    run = 1'b0;
    cyc();
    chk("halt_reset_halted", 32'(halted), 32'd0);
    chk("halt_reset_illegal", 32'(illegal_op), 32'd0);
    reset_n = 1'b1;

    // randomized instruction stream
    repeat (150) begin
      repeat ($urandom_range(0, 2)) cyc();
      r = int'($urandom_range(0, 99));
      if (r < 75)      op = legal_ops[$urandom_range(0, 8)];
      else if (r < 85) op = 5'd26;
      else if (r < 96) op = 5'($urandom_range(0, 31));
      else             op = 5'd27;
      rnd = $urandom();
      ir = {op, rnd[26:0]};
      mem_ready = 1'($urandom_range(0, 1));
      run = 1'b1;
      cyc();
      run = 1'b0;
      for (int k = 0; k < 60; k++) begin
        if (plan.size() == 0) break;
        mem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0) begin
          reset_n = 1'b0;
          cyc();
          reset_n = 1'b1;
        end else begin
          cyc();
        end
      end
      if (plan.size() != 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rand_timeout: instruction did not complete");
      end
      if (m_halt) begin
        run = 1'b1;
        repeat (3) cyc();
        reset_n = 1'b0;
        run = 1'b0;
        cyc();
        reset_n = 1'b1;
      end
    end

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
